// File: rtl/inst_fetch_if.sv
// Purpose: bundles the fetch unit's memory handshake and its IF/ID-facing
//          signals so the fetch unit and its environment connect through
//          one port.
// Signals:
//   stall         : downstream IF/ID cannot accept this cycle
//   branch_flag   : redirect request (flush) to branch_target
//   branch_target : redirect address (low two bits ignored by the fetch unit)
//   inst_req      : instruction-memory request
//   inst_addr     : instruction-memory request address
//   inst_ack      : memory accepted the request; inst_rdata valid this cycle
//   inst_rdata    : fetched instruction word
//   if_pc         : fetch result presented to IF/ID, instruction address
//   if_inst       : fetch result presented to IF/ID, instruction word
//   if_valid      : fetch result presented to IF/ID, valid
// Modports: master = fetch unit, slave = memory/pipeline environment.
interface inst_fetch_if;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  modport master (
    input  stall, branch_flag, branch_target, inst_ack, inst_rdata,
    output inst_req, inst_addr, if_pc, if_inst, if_valid
  );

  modport slave (
    output stall, branch_flag, branch_target, inst_ack, inst_rdata,
    input  inst_req, inst_addr, if_pc, if_inst, if_valid
  );
endinterface

// File: rtl/inst_fetch.sv
// Purpose: instruction fetch stage. Issues one request at a time to
//          instruction memory, holds request/address stable until ack,
//          presents fetched words to IF/ID with a one-entry skid buffer for
//          downstream stalls, and handles branch redirects including
//          redirects that land while a request is still outstanding.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : inst_fetch_if.master (stall/branch inputs, memory handshake,
//           registered if_pc/if_inst/if_valid outputs)
// Parameter:
//   RESET_PC : first fetch address after reset
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  inst_fetch_if.master bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_REQ, S_DROP} state_e;

  state_e            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt;
  logic [XLEN-1:0]   r_addr, w_addr_nxt;
  logic              r_req, w_req_nxt;
  logic [XLEN-1:0]   r_if_pc, w_if_pc_nxt;
  logic [XLEN-1:0]   r_if_inst, w_if_inst_nxt;
  logic              r_if_valid, w_if_valid_nxt;
  logic [XLEN-1:0]   r_skid_pc, w_skid_pc_nxt;
  logic [XLEN-1:0]   r_skid_inst, w_skid_inst_nxt;
  logic              r_skid_valid, w_skid_valid_nxt;

  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_pc_inc;
  logic              w_xfer;
  logic              w_take;

  assign w_target = bus.branch_target & ~XLEN'(3);
  assign w_pc_inc = r_pc + XLEN'(4);
  assign w_xfer   = r_if_valid & ~bus.stall;

  assign bus.inst_req  = r_req;
  assign bus.inst_addr = r_addr;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_inst   = r_if_inst;
  assign bus.if_valid  = r_if_valid;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_req        <= 1'b0;
      r_if_pc      <= '0;
      r_if_inst    <= '0;
      r_if_valid   <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_inst  <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_addr       <= w_addr_nxt;
      r_req        <= w_req_nxt;
      r_if_pc      <= w_if_pc_nxt;
      r_if_inst    <= w_if_inst_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_inst  <= w_skid_inst_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  // Next-state, request and output/skid update.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_addr_nxt       = r_addr;
    w_if_pc_nxt      = r_if_pc;
    w_if_inst_nxt    = r_if_inst;
    w_if_valid_nxt   = r_if_valid;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_inst_nxt  = r_skid_inst;
    w_skid_valid_nxt = r_skid_valid;
    w_take           = 1'b0;

    case (r_state)
      S_BOOT: w_state_nxt = S_IDLE;
      // Only start a fetch once the skid has somewhere to drain.
      S_IDLE: begin
        if (!r_skid_valid) begin
          w_state_nxt = S_REQ;
          w_addr_nxt  = r_pc;
        end
      end
      S_REQ: begin
        if (bus.inst_ack) begin
          w_take   = 1'b1;
          w_pc_nxt = w_pc_inc;
          if (!r_if_valid || !bus.stall) begin
            w_addr_nxt = w_pc_inc;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      // Abandoned request completes here; its data is thrown away.
      S_DROP: begin
        if (bus.inst_ack) begin
          w_state_nxt = S_REQ;
          w_addr_nxt  = r_pc;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase

    if (w_take && (!r_if_valid || !bus.stall)) begin
      w_if_pc_nxt    = r_pc;
      w_if_inst_nxt  = bus.inst_rdata;
      w_if_valid_nxt = 1'b1;
    end else if (w_take) begin
      w_skid_pc_nxt    = r_pc;
      w_skid_inst_nxt  = bus.inst_rdata;
      w_skid_valid_nxt = 1'b1;
    end else if (w_xfer) begin
      if (r_skid_valid) begin
        w_if_pc_nxt      = r_skid_pc;
        w_if_inst_nxt    = r_skid_inst;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_if_valid_nxt = 1'b0;
      end
    end

    // Redirect overrides everything above; an outstanding request without
    // ack must still be completed, so the address is held and we drop it.
    if (bus.branch_flag) begin
      w_pc_nxt         = w_target;
      w_if_pc_nxt      = '0;
      w_if_inst_nxt    = '0;
      w_if_valid_nxt   = 1'b0;
      w_skid_valid_nxt = 1'b0;
      case (r_state)
        S_REQ: begin
          if (bus.inst_ack) begin
            w_state_nxt = S_REQ;
            w_addr_nxt  = w_target;
          end else begin
            w_state_nxt = S_DROP;
            w_addr_nxt  = r_addr;
          end
        end
        S_DROP: begin
          w_state_nxt = S_DROP;
          w_addr_nxt  = r_addr;
        end
        default: begin
          w_state_nxt = S_REQ;
          w_addr_nxt  = w_target;
        end
      endcase
    end

    w_req_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_DROP);
  end
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int unsigned mem_lat;
  int unsigned n_xfer;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_outs(input string tag, input logic req, input logic [31:0] addr,
                          input logic v, input logic [31:0] pc);
    chk({tag, ".inst_req"}, 32'(bus.inst_req), 32'(req));
    chk({tag, ".inst_addr"}, bus.inst_addr, addr);
    chk({tag, ".if_valid"}, 32'(bus.if_valid), 32'(v));
    if (v) chk({tag, ".if_pc"}, bus.if_pc, pc);
  endtask

  // Memory responder: acks a held request after mem_lat wait cycles.
  initial begin : mem_resp
    int unsigned cnt;
    cnt = 0;
    bus.inst_ack   = 1'b0;
    bus.inst_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.inst_req && rst_n) begin
        if (cnt >= mem_lat) begin
          bus.inst_ack   = 1'b1;
          bus.inst_rdata = mem_word(bus.inst_addr);
          cnt = 0;
        end else begin
          bus.inst_ack   = 1'b0;
          bus.inst_rdata = 32'hDEAD_BEEF;
          cnt++;
        end
      end else begin
        bus.inst_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Stream model: delivered words must be consecutive from the last
  // redirect (or reset), each carrying the memory word for its address.
  initial begin : compare
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_pending;
    logic        prev_branch;
    exp_pc = RESET_PC;
    prev_addr = 32'h0;
    prev_pending = 1'b0;
    prev_branch = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst.if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst.inst_req", 32'(bus.inst_req), 32'd0);
        chk("rst.inst_addr", bus.inst_addr, RESET_PC);
        chk("rst.if_pc", bus.if_pc, 32'h0);
        chk("rst.if_inst", bus.if_inst, 32'h0);
        exp_pc = RESET_PC;
        prev_pending = 1'b0;
        prev_branch = 1'b0;
      end else begin
        if (prev_pending) begin
          chk("req_hold.inst_req", 32'(bus.inst_req), 32'd1);
          chk("req_hold.inst_addr", bus.inst_addr, prev_addr);
        end
        if (prev_branch) begin
          chk("flush.if_valid", 32'(bus.if_valid), 32'd0);
          chk("flush.if_pc", bus.if_pc, 32'h0);
        end
        if (bus.if_valid) begin
          chk("stream.if_pc", bus.if_pc, exp_pc);
          chk("stream.if_inst", bus.if_inst, mem_word(bus.if_pc));
        end
        prev_pending = bus.inst_req && !bus.inst_ack;
        prev_addr = bus.inst_addr;
        prev_branch = bus.branch_flag;
        if (bus.branch_flag) begin
          exp_pc = bus.branch_target & ~32'd3;
        end else if (bus.if_valid && !bus.stall) begin
          exp_pc = exp_pc + 32'd4;
          n_xfer++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] pat;
    int unsigned n0;
    int k;
    checks = 0;
    errors = 0;
    mem_lat = 0;
    n_xfer = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.branch_flag = 1'b0;
    bus.branch_target = 32'h0;
    tick();
    tick();
    exp_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset.if_inst", bus.if_inst, 32'h0);

    // Straight-line streaming with ack tied high.
    rst_n = 1'b1;
    tick(); exp_outs("boot", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); exp_outs("first_req", 1'b1, 32'h0, 1'b0, 32'h0);
    tick(); exp_outs("stream0", 1'b1, 32'h4, 1'b1, 32'h0);
    chk("stream0.if_inst", bus.if_inst, mem_word(32'h0));
    tick(); exp_outs("stream1", 1'b1, 32'h8, 1'b1, 32'h4);
    tick(); exp_outs("stream2", 1'b1, 32'hC, 1'b1, 32'h8);

    // Three-cycle stall: word 0xC parks in the skid, request drops.
    bus.stall = 1'b1;
    tick(); exp_outs("stall0", 1'b0, 32'hC, 1'b1, 32'h8);
    tick(); exp_outs("stall1", 1'b0, 32'hC, 1'b1, 32'h8);
    tick(); exp_outs("stall2", 1'b0, 32'hC, 1'b1, 32'h8);
    bus.stall = 1'b0;
    tick(); exp_outs("skid_out", 1'b0, 32'hC, 1'b1, 32'hC);
    tick(); exp_outs("refetch", 1'b1, 32'h10, 1'b0, 32'h0);
    tick(); exp_outs("resume", 1'b1, 32'h14, 1'b1, 32'h10);

    // Branch coinciding with an ack: data dropped, unaligned target masked.
    bus.branch_flag = 1'b1;
    bus.branch_target = 32'h0000_0103;
    tick();
    bus.branch_flag = 1'b0;
    exp_outs("br_ack", 1'b1, 32'h100, 1'b0, 32'h0);
    chk("br_ack.if_pc", bus.if_pc, 32'h0);
    tick(); exp_outs("br_target", 1'b1, 32'h104, 1'b1, 32'h100);

    // Slow memory; branch in the first wait cycle forces a drop.
    mem_lat = 3;
    bus.branch_flag = 1'b1;
    bus.branch_target = 32'h0000_0040;
    tick();
    bus.branch_flag = 1'b0;
    exp_outs("drop0", 1'b1, 32'h104, 1'b0, 32'h0);
    tick(); exp_outs("drop1", 1'b1, 32'h104, 1'b0, 32'h0);
    tick(); exp_outs("drop2", 1'b1, 32'h104, 1'b0, 32'h0);
    tick(); exp_outs("drop_done", 1'b1, 32'h40, 1'b0, 32'h0);
    k = 0;
    while (!bus.if_valid && k < 10) begin
      tick();
      k++;
    end
    chk("late.if_valid", 32'(bus.if_valid), 32'd1);
    chk("late.if_pc", bus.if_pc, 32'h40);

    // Address wrap at the top of the address space.
    mem_lat = 0;
    tick();
    tick();
    bus.branch_flag = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    tick();
    bus.branch_flag = 1'b0;
    exp_outs("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick(); exp_outs("wrap_next", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);

    // Irregular stall pattern; ordering is checked by the stream model.
    pat = 16'b0110_0011_1000_1101;
    n0 = n_xfer;
    for (int i = 0; i < 16; i++) begin
      bus.stall = pat[i];
      tick();
    end
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pattern.progress", 32'(n_xfer - n0 >= 32'd3), 32'd1);

    // Reset while the skid holds a word.
    bus.stall = 1'b1;
    tick();
    chk("skid_setup.inst_req", 32'(bus.inst_req), 32'd0);
    chk("skid_setup.if_valid", 32'(bus.if_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_outs("rst_skid", 1'b0, RESET_PC, 1'b0, 32'h0);
    chk("rst_skid.if_pc", bus.if_pc, 32'h0);
    chk("rst_skid.if_inst", bus.if_inst, 32'h0);
    bus.stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); exp_outs("reboot_boot", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); exp_outs("reboot_req", 1'b1, 32'h0, 1'b0, 32'h0);
    tick(); exp_outs("reboot_data", 1'b1, 32'h4, 1'b1, 32'h0);

    // Reset while a dropped request is still outstanding.
    mem_lat = 8;
    bus.branch_flag = 1'b1;
    bus.branch_target = 32'h0000_0200;
    tick();
    bus.branch_flag = 1'b0;
    exp_outs("drop_setup", 1'b1, 32'h4, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_outs("rst_drop", 1'b0, RESET_PC, 1'b0, 32'h0);
    mem_lat = 0;
    tick();
    rst_n = 1'b1;
    tick(); exp_outs("reboot2_boot", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); exp_outs("reboot2_req", 1'b1, 32'h0, 1'b0, 32'h0);
    tick(); exp_outs("reboot2_data", 1'b1, 32'h4, 1'b1, 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-004 stall  input  1  SHALL indicate that the downstream IF/ID register cannot accept this cycle.
REQ-005 branch_flag  input  1  SHALL request a redirect (flush) to branch_target.
REQ-006 branch_target  input  32  SHALL be the redirect address; bits [1:0] are forced to 0 internally.
REQ-007 inst_req  output  1  SHALL be the instruction-memory request.
REQ-008 inst_addr  output  32  SHALL be the registered request address.
REQ-009 inst_ack  input  1  SHALL indicate that the memory accepted the request and drives inst_rdata this cycle.
REQ-010 inst_rdata  input  32  SHALL be the fetched word, valid only when inst_ack=1.
REQ-011 if_pc / if_inst / if_valid  output  32/32/1  SHALL be the registered fetch result presented to IF/ID.

Function
REQ-012 Downstream transfer SHALL occur at a posedge where if_valid=1 and stall=0.
REQ-013 States SHALL be BOOT, IDLE, REQ and DROP; inst_req=1 only in REQ and DROP.
REQ-014 BOOT SHALL last exactly one cycle after reset release, then go to IDLE.
REQ-015 IDLE SHALL go to REQ when the skid entry is empty; on entry inst_addr<=pc.
REQ-016 Once inst_req=1, inst_req and inst_addr SHALL stay stable until the inst_ack cycle, regardless of stall.
REQ-017 On ack in REQ without branch: if if_valid=0 or stall=0, output SHALL load {pc, inst_rdata, valid=1} and next state REQ with inst_addr<=pc+4; otherwise the data SHALL go to the one-entry skid and next state IDLE.
REQ-018 pc SHALL advance pc<=pc+4 on every accepted (non-dropped) ack, wrapping modulo 2^32.
REQ-019 On a transfer with skid valid, output SHALL load the skid contents and the skid SHALL clear in the same edge.
REQ-020 On a transfer with skid empty and no new data, if_valid SHALL clear to 0.
REQ-021 branch_flag SHALL take priority over stall and ack: pc<=target, if_valid<=0, if_pc<=0, if_inst<=0, skid cleared.
REQ-022 Branch in IDLE/BOOT-exit SHALL go to REQ with inst_addr<=target.
REQ-023 Branch in REQ with inst_ack=1 SHALL discard inst_rdata and go to REQ with inst_addr<=target.
REQ-024 Branch in REQ with inst_ack=0 SHALL go to DROP; inst_addr holds the abandoned address.
REQ-025 DROP SHALL keep the request asserted, discard data on ack, then go to REQ with inst_addr<=pc.
REQ-026 A further branch in DROP SHALL overwrite pc with the newest target and remain in DROP.
REQ-027 Throughput SHALL be one instruction per cycle when inst_ack is tied to 1 and stall=0.
REQ-028 Latency SHALL be one cycle from the ack edge to if_valid=1.

Reset
REQ-029 While rst=0, the block SHALL asynchronously force state=BOOT, pc=RESET_PC, inst_addr=RESET_PC, inst_req=0, if_valid=0, if_pc=0, if_inst=0, skid empty.
REQ-030 Reset asserted mid-request SHALL abandon the request without waiting for ack; the memory tolerates inst_req dropping under reset.

Verification
REQ-031 Reset release, inst_ack=1 constant, stall=0 -> inst_addr 0,4,8,... on consecutive cycles; if_pc follows one cycle later with if_valid=1.
REQ-032 stall=1 for 3 cycles while if_valid=1 -> if_pc/if_inst held; one word lands in skid; inst_req=0; after release, words delivered in order with no loss or duplicate.
REQ-033 branch_flag=1, target 32'h0000_0103, ack same cycle -> data dropped, next inst_addr=32'h0000_0100, if_valid=0 for one cycle.
REQ-034 Memory acks 3 cycles late; branch to 32'h40 in the first wait cycle -> inst_addr holds old value until ack, dropped; next request 32'h40.
REQ-035 pc=32'hFFFF_FFFC fetched -> next inst_addr=32'h0000_0000.
REQ-036 rst pulsed low while skid valid and DROP active -> all outputs at reset values immediately; fetch restarts at RESET_PC after one BOOT cycle.
